// File: rtl/load_pkg.sv
// Shared definitions for the load path: funct3 encodings, FSM states and
// the predicates that classify a request.
package load_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2
   } state_t;

   // Only the five load encodings are legal; everything else is reported as an error.
   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // A load needs a second word when its bytes run past byte 3 of the first word.
   function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
      return (((f3 == F3_LH) || (f3 == F3_LHU)) && (off == 2'd3)) ||
             ((f3 == F3_LW) && (off != 2'd0));
   endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Request, data-memory and writeback signals of the load unit.
// slave is the load unit itself; master is its environment
// (pipeline issuing requests, memory returning read data, writeback sink).
interface load_align_unit_if #(
   parameter int DMEM_AW = 14
);
   logic               req_valid;
   logic               req_ready;
   logic [31:0]        req_addr;
   logic [2:0]         req_funct3;
   logic [4:0]         req_rd;

   logic               dmem_re;
   logic [DMEM_AW-1:0] dmem_addr;
   logic [31:0]        dmem_rdata;

   logic               wb_valid;
   logic [31:0]        wb_data;
   logic [4:0]         wb_rd;
   logic               load_err;

   modport master (
      output req_valid, req_addr, req_funct3, req_rd, dmem_rdata,
      input  req_ready, dmem_re, dmem_addr, wb_valid, wb_data, wb_rd, load_err
   );

   modport slave (
      input  req_valid, req_addr, req_funct3, req_rd, dmem_rdata,
      output req_ready, dmem_re, dmem_addr, wb_valid, wb_data, wb_rd, load_err
   );
endinterface

// File: rtl/load_extend.sv
// Byte/half/word extraction from a little-endian 64-bit window with
// sign or zero extension. Pure combinational.
module load_extend
   import load_pkg::*;
(
   input  logic [63:0] window,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [63:0] shifted;
   logic [31:0] win;

   assign shifted = window >> {offset, 3'b000};
   assign win     = shifted[31:0];

   // Select the width and extension kind requested by funct3.
   always_comb begin
      result = 32'h0;
      case (funct3)
         F3_LB:   result = {{24{win[7]}}, win[7:0]};
         F3_LBU:  result = {24'h0, win[7:0]};
         F3_LH:   result = {{16{win[15]}}, win[15:0]};
         F3_LHU:  result = {16'h0, win[15:0]};
         F3_LW:   result = win;
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// Load path: accepts one load, reads one or two dmem words, extracts and
// extends the addressed field, and emits a registered one-cycle writeback.
module load_align_unit
   import load_pkg::*;
#(
   parameter int DMEM_AW  = 14,
   parameter bit SPLIT_EN = 1'b1
) (
   input logic             clk,
   input logic             rst,
   load_align_unit_if.slave bus
);

   localparam logic [DMEM_AW-1:0] WORD_ONE = DMEM_AW'(1);

   state_t             state, state_nxt;
   logic [1:0]         off_q;
   logic [2:0]         f3_q;
   logic [4:0]         rd_q;
   logic [DMEM_AW-1:0] word_q;
   logic [31:0]        lo_word;

   logic               wb_valid_q;
   logic [31:0]        wb_data_q;
   logic [4:0]         wb_rd_q;
   logic               load_err_q;

   logic               ready_c;
   logic               re_c;
   logic [DMEM_AW-1:0] addr_c;

   logic               accept;
   logic               legal_in;
   logic               split_q;
   logic [63:0]        window;
   logic [31:0]        ext_res;

   // Address bits above the dmem range are not decoded.
   logic unused_addr;
   assign unused_addr = ^bus.req_addr[31:DMEM_AW+2];

   assign accept   = bus.req_valid && ready_c;
   assign legal_in = f3_legal(bus.req_funct3);
   assign split_q  = is_split(f3_q, off_q);

   // RD0 sees only the first word (upper half zero); RD1 merges both words.
   assign window = (state == RD1) ? {bus.dmem_rdata, lo_word} : {32'h0, bus.dmem_rdata};

   load_extend u_ext (
      .window (window),
      .offset (off_q),
      .funct3 (f3_q),
      .result (ext_res)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && legal_in) state_nxt = RD0;
         RD0:     state_nxt = (split_q && SPLIT_EN) ? RD1 : IDLE;
         RD1:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and dmem read strobes; reads are suppressed while in reset.
   always_comb begin
      ready_c = (state == IDLE);
      re_c    = 1'b0;
      addr_c  = word_q;
      case (state)
         IDLE: begin
            addr_c = bus.req_addr[DMEM_AW+1:2];
            re_c   = accept && legal_in;
         end
         RD0: begin
            if (split_q && SPLIT_EN) begin
               re_c   = 1'b1;
               addr_c = word_q + WORD_ONE;  // wraps modulo 2^DMEM_AW
            end
         end
         default: ;
      endcase
      if (rst) re_c = 1'b0;
   end

   // Request latching, split low-word capture and writeback registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         off_q      <= 2'd0;
         f3_q       <= 3'd0;
         rd_q       <= 5'd0;
         word_q     <= '0;
         lo_word    <= 32'h0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= 32'h0;
         wb_rd_q    <= 5'd0;
         load_err_q <= 1'b0;
      end else begin
         wb_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  off_q  <= bus.req_addr[1:0];
                  f3_q   <= bus.req_funct3;
                  rd_q   <= bus.req_rd;
                  word_q <= bus.req_addr[DMEM_AW+1:2];
                  if (!legal_in) begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= 32'h0;
                     wb_rd_q    <= bus.req_rd;
                     load_err_q <= 1'b1;
                  end
               end
            end
            RD0: begin
               if (split_q) begin
                  if (SPLIT_EN) begin
                     lo_word <= bus.dmem_rdata;
                  end else begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= 32'h0;
                     wb_rd_q    <= rd_q;
                     load_err_q <= 1'b1;
                  end
               end else begin
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= ext_res;
                  wb_rd_q    <= rd_q;
                  load_err_q <= 1'b0;
               end
            end
            RD1: begin
               wb_valid_q <= 1'b1;
               wb_data_q  <= ext_res;
               wb_rd_q    <= rd_q;
               load_err_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.dmem_re   = re_c;
   assign bus.dmem_addr = addr_c;
   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.load_err  = load_err_q;

endmodule
